// File: rtl/store_queue_fwd_if.sv
// Store queue bus: dispatch, CDB, AGU, commit, load lookup, D$ write port and status.
interface store_queue_fwd_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned ROB_SZ = 32,
  parameter int unsigned PRF_SZ = 64,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned ROB_W = $clog2(ROB_SZ);
  localparam int unsigned PRF_W = $clog2(PRF_SZ);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMT_W = $clog2(WAYS) + 1;

  logic                         except;
  logic [CMT_W-1:0]             commit_cnt;

  logic [WAYS-1:0]              disp_en;
  logic [WAYS-1:0][1:0]         disp_size;
  logic [WAYS-1:0][DATA_W-1:0]  disp_data;
  logic [WAYS-1:0]              disp_data_valid;
  logic [WAYS-1:0][PRF_W-1:0]   disp_tag;
  logic [WAYS-1:0][ROB_W-1:0]   disp_rob_idx;

  logic [WAYS-1:0]              cdb_valid;
  logic [WAYS-1:0][PRF_W-1:0]   cdb_tag;
  logic [WAYS-1:0][DATA_W-1:0]  cdb_data;

  logic [WAYS-1:0]              agu_valid;
  logic [WAYS-1:0][ROB_W-1:0]   agu_rob_idx;
  logic [WAYS-1:0][ADDR_W-1:0]  agu_addr;

  logic                         ld_valid;
  logic [ADDR_W-1:0]            ld_addr;
  logic [1:0]                   ld_size;
  logic [PTR_W-1:0]             ld_sq_tail;
  logic                         ld_fwd_hit;
  logic [DATA_W-1:0]            ld_fwd_data;
  logic                         ld_stall;

  logic                         dc_wr_en;
  logic                         dc_wr_ready;
  logic [ADDR_W-1:0]            dc_wr_addr;
  logic [DATA_W-1:0]            dc_wr_data;
  logic [1:0]                   dc_wr_size;

  logic [PTR_W-1:0]             sq_head;
  logic [PTR_W-1:0]             sq_tail;
  logic [CNT_W-1:0]             num_free;
  logic [CNT_W-1:0]             num_senior;

  modport master (
    output except, commit_cnt,
    output disp_en, disp_size, disp_data, disp_data_valid, disp_tag, disp_rob_idx,
    output cdb_valid, cdb_tag, cdb_data,
    output agu_valid, agu_rob_idx, agu_addr,
    output ld_valid, ld_addr, ld_size, ld_sq_tail,
    input  ld_fwd_hit, ld_fwd_data, ld_stall,
    input  dc_wr_en, dc_wr_addr, dc_wr_data, dc_wr_size,
    output dc_wr_ready,
    input  sq_head, sq_tail, num_free, num_senior
  );

  modport slave (
    input  except, commit_cnt,
    input  disp_en, disp_size, disp_data, disp_data_valid, disp_tag, disp_rob_idx,
    input  cdb_valid, cdb_tag, cdb_data,
    input  agu_valid, agu_rob_idx, agu_addr,
    input  ld_valid, ld_addr, ld_size, ld_sq_tail,
    output ld_fwd_hit, ld_fwd_data, ld_stall,
    output dc_wr_en, dc_wr_addr, dc_wr_data, dc_wr_size,
    input  dc_wr_ready,
    output sq_head, sq_tail, num_free, num_senior
  );
endinterface

// File: rtl/store_queue_fwd.sv
// Store queue with senior-store retention, multi-commit, D$ drain and load forwarding.
module store_queue_fwd #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned ROB_SZ = 32,
  parameter int unsigned PRF_SZ = 64,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
) (
  input logic              clock,
  input logic              reset,
  store_queue_fwd_if.slave sq
);
  localparam int unsigned ROB_W = $clog2(ROB_SZ);
  localparam int unsigned PRF_W = $clog2(PRF_SZ);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMT_W = $clog2(WAYS) + 1;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned EXT_W = ADDR_W + 1;

  typedef struct packed {
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic [PRF_W-1:0]  tag;
    logic [ROB_W-1:0]  rob_idx;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              committed;
    logic              valid;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] num_free_q, num_free_d;
  logic [CNT_W-1:0] num_senior_q, num_senior_d;
  logic [CNT_W-1:0] n_disp_c;
  logic             drain_c;

  logic              fwd_hit;
  logic              fwd_stall;
  logic [DATA_W-1:0] fwd_data;

  // Byte count of an access size, in extended address width.
  function automatic logic [EXT_W-1:0] size_bytes(input logic [1:0] sz);
    return EXT_W'(1) << sz;
  endfunction

  // D$ write port presents the head entry once it is senior.
  assign sq.dc_wr_en   = !reset && entries_q[head_q].valid && entries_q[head_q].committed;
  assign sq.dc_wr_addr = entries_q[head_q].addr;
  assign sq.dc_wr_data = entries_q[head_q].data;
  assign sq.dc_wr_size = entries_q[head_q].size;
  assign drain_c       = sq.dc_wr_en && sq.dc_wr_ready;

  assign sq.sq_head    = head_q;
  assign sq.sq_tail    = tail_q;
  assign sq.num_free   = num_free_q;
  assign sq.num_senior = num_senior_q;

  assign sq.ld_fwd_hit  = fwd_hit;
  assign sq.ld_stall    = fwd_stall;
  assign sq.ld_fwd_data = fwd_data;

  // Next state: wakeup, address resolve, commit, drain, dispatch, then exception flush.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] senior_nx;
    entries_d    = entries_q;
    head_d       = head_q;
    tail_d       = tail_q;
    num_free_d   = num_free_q;
    num_senior_d = num_senior_q;
    n_disp_c     = '0;
    idx          = '0;
    senior_nx    = '0;

    for (int e = 0; e < int'(DEPTH); e++) begin
      if (entries_q[e].valid && !entries_q[e].data_valid) begin
        // Descending scan so the lowest matching lane wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
          if (sq.cdb_valid[w] && (sq.cdb_tag[w] == entries_q[e].tag)) begin
            entries_d[e].data       = sq.cdb_data[w];
            entries_d[e].data_valid = 1'b1;
          end
        end
      end
    end

    for (int w = 0; w < int'(WAYS); w++) begin
      if (sq.agu_valid[w]) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          if (entries_q[e].valid && (entries_q[e].rob_idx == sq.agu_rob_idx[w])) begin
            entries_d[e].addr       = sq.agu_addr[w];
            entries_d[e].addr_valid = 1'b1;
          end
        end
      end
    end

    // Seniors are contiguous from head, so the oldest uncommitted entry sits at head+num_senior.
    for (int k = 0; k < int'(WAYS); k++) begin
      if (CMT_W'(k) < sq.commit_cnt) begin
        idx = head_q + num_senior_q[PTR_W-1:0] + PTR_W'(k);
        entries_d[idx].committed = 1'b1;
      end
    end

    if (drain_c) begin
      entries_d[head_q].valid     = 1'b0;
      entries_d[head_q].committed = 1'b0;
    end
    senior_nx = num_senior_q + CNT_W'(sq.commit_cnt) - CNT_W'(drain_c);
    head_d    = head_q + PTR_W'(drain_c);

    // Compact enabled lanes into consecutive slots; a full queue may reuse the slot drained this cycle.
    for (int w = 0; w < int'(WAYS); w++) begin
      if (sq.disp_en[w]) begin
        if (!sq.except) begin
          idx = tail_q + n_disp_c[PTR_W-1:0];
          entries_d[idx].valid      = 1'b1;
          entries_d[idx].committed  = 1'b0;
          entries_d[idx].addr_valid = 1'b0;
          entries_d[idx].addr       = '0;
          entries_d[idx].size       = sq.disp_size[w];
          entries_d[idx].data       = sq.disp_data[w];
          entries_d[idx].data_valid = sq.disp_data_valid[w];
          entries_d[idx].tag        = sq.disp_tag[w];
          entries_d[idx].rob_idx    = sq.disp_rob_idx[w];
          if (!sq.disp_data_valid[w]) begin
            for (int c = int'(WAYS) - 1; c >= 0; c--) begin
              if (sq.cdb_valid[c] && (sq.cdb_tag[c] == sq.disp_tag[w])) begin
                entries_d[idx].data       = sq.cdb_data[c];
                entries_d[idx].data_valid = 1'b1;
              end
            end
          end
        end
        n_disp_c = n_disp_c + CNT_W'(1);
      end
    end

    if (sq.except) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (!entries_d[e].committed) begin
          entries_d[e].valid = 1'b0;
        end
      end
      tail_d     = head_d + senior_nx[PTR_W-1:0];
      num_free_d = CNT_W'(DEPTH) - senior_nx;
    end else begin
      tail_d     = tail_q + n_disp_c[PTR_W-1:0];
      num_free_d = num_free_q - n_disp_c + CNT_W'(drain_c);
    end
    num_senior_d = senior_nx;
  end

  // Load disambiguation: youngest overlapping older store decides forward or stall.
  always_comb begin
    logic [PTR_W-1:0]  span;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  yidx;
    logic              any_unres;
    logic              found;
    logic [EXT_W-1:0]  l_lo, l_hi, s_lo, s_hi, shift;
    logic [DATA_W-1:0] shifted;
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    span      = sq.ld_sq_tail - head_q;
    idx       = '0;
    yidx      = '0;
    any_unres = 1'b0;
    found     = 1'b0;
    l_lo      = EXT_W'(sq.ld_addr);
    l_hi      = l_lo + size_bytes(sq.ld_size);
    s_lo      = '0;
    s_hi      = '0;
    shift     = '0;
    shifted   = '0;

    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_q + PTR_W'(k);
      if ((PTR_W'(k) < span) && entries_q[idx].valid) begin
        if (!entries_q[idx].addr_valid) begin
          any_unres = 1'b1;
        end else begin
          s_lo = EXT_W'(entries_q[idx].addr);
          s_hi = s_lo + size_bytes(entries_q[idx].size);
          if ((s_lo < l_hi) && (l_lo < s_hi)) begin
            found = 1'b1;
            yidx  = idx;
          end
        end
      end
    end

    if (sq.ld_valid && !reset) begin
      if (any_unres) begin
        fwd_stall = 1'b1;
      end else if (found) begin
        s_lo = EXT_W'(entries_q[yidx].addr);
        s_hi = s_lo + size_bytes(entries_q[yidx].size);
        if ((s_lo <= l_lo) && (l_hi <= s_hi) && entries_q[yidx].data_valid) begin
          fwd_hit = 1'b1;
          shift   = l_lo - s_lo;
          shifted = entries_q[yidx].data >> {shift, 3'b000};
          for (int b = 0; b < int'(BYTES); b++) begin
            if (EXT_W'(b) < (l_hi - l_lo)) begin
              fwd_data[8*b +: 8] = shifted[8*b +: 8];
            end
          end
        end else begin
          fwd_stall = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        entries_q[e] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      num_free_q   <= CNT_W'(DEPTH);
      num_senior_q <= '0;
    end else begin
      entries_q    <= entries_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      num_free_q   <= num_free_d;
      num_senior_q <= num_senior_d;
    end
  end

  // Dispatch must fit in the free slots, counting the one a same-cycle drain releases.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (n_disp_c <= (num_free_q + CNT_W'(drain_c)))
        else $error("store_queue_fwd: dispatch exceeds free entries");
    end
  end
endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd with hand-computed expectations.
module tb_store_queue_fwd;
  logic clock = 1'b0;
  logic reset;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  store_queue_fwd_if bus ();
  store_queue_fwd dut (.clock(clock), .reset(reset), .sq(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_pulses();
    bus.except     = 1'b0;
    bus.commit_cnt = '0;
    bus.disp_en    = '0;
    bus.cdb_valid  = '0;
    bus.agu_valid  = '0;
    bus.ld_valid   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_pulses();
    #1;
  endtask

  task automatic set_disp(input int lane, input logic [1:0] sz, input logic [63:0] d,
                          input logic dv, input logic [5:0] tag, input logic [4:0] rob);
    bus.disp_en[lane]         = 1'b1;
    bus.disp_size[lane]       = sz;
    bus.disp_data[lane]       = d;
    bus.disp_data_valid[lane] = dv;
    bus.disp_tag[lane]        = tag;
    bus.disp_rob_idx[lane]    = rob;
  endtask

  task automatic set_agu(input int lane, input logic [4:0] rob, input logic [15:0] a);
    bus.agu_valid[lane]   = 1'b1;
    bus.agu_rob_idx[lane] = rob;
    bus.agu_addr[lane]    = a;
  endtask

  task automatic set_ld(input logic [15:0] a, input logic [1:0] sz, input logic [3:0] t);
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = a;
    bus.ld_size    = sz;
    bus.ld_sq_tail = t;
    #1;
  endtask

  task automatic chk_ld(input string tag, input logic hit, input logic stall, input logic [63:0] d);
    check({tag, "_hit"},   64'(bus.ld_fwd_hit), 64'(hit));
    check({tag, "_stall"}, 64'(bus.ld_stall),   64'(stall));
    check({tag, "_data"},  bus.ld_fwd_data,     d);
  endtask

  task automatic chk_ptrs(input string tag, input logic [3:0] h, input logic [3:0] t,
                          input logic [4:0] fr, input logic [4:0] sn);
    check({tag, "_head"},   64'(bus.sq_head),    64'(h));
    check({tag, "_tail"},   64'(bus.sq_tail),    64'(t));
    check({tag, "_free"},   64'(bus.num_free),   64'(fr));
    check({tag, "_senior"}, 64'(bus.num_senior), 64'(sn));
  endtask

  initial begin
    reset               = 1'b1;
    bus.dc_wr_ready     = 1'b0;
    bus.disp_size       = '0;
    bus.disp_data       = '0;
    bus.disp_data_valid = '0;
    bus.disp_tag        = '0;
    bus.disp_rob_idx    = '0;
    bus.cdb_tag         = '0;
    bus.cdb_data        = '0;
    bus.agu_rob_idx     = '0;
    bus.agu_addr        = '0;
    clear_pulses();
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = 16'h0100;
    bus.ld_size    = 2'd3;
    bus.ld_sq_tail = 4'd0;
    #1;
    check("rst_dc_wr_en", 64'(bus.dc_wr_en), 64'd0);
    chk_ld("rst_ld", 1'b0, 1'b0, 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_pulses();
    #1;
    chk_ptrs("rst", 4'd0, 4'd0, 5'd16, 5'd0);

    // Two-lane dispatch, then flush with no seniors.
    set_disp(0, 2'd3, 64'h1, 1'b1, 6'd0, 5'd0);
    set_disp(1, 2'd3, 64'h2, 1'b1, 6'd0, 5'd1);
    tick();
    chk_ptrs("disp2", 4'd0, 4'd2, 5'd14, 5'd0);
    check("disp2_dc_wr_en", 64'(bus.dc_wr_en), 64'd0);
    bus.except = 1'b1;
    tick();
    chk_ptrs("flush0", 4'd0, 4'd0, 5'd16, 5'd0);

    // Same-cycle CDB wakeup at dispatch.
    set_disp(0, 2'd3, 64'h0, 1'b0, 6'd5, 5'd2);
    bus.cdb_valid   = 2'b11;
    bus.cdb_tag[0]  = 6'd5;
    bus.cdb_data[0] = 64'hAB;
    bus.cdb_tag[1]  = 6'd9;
    bus.cdb_data[1] = 64'hFF;
    tick();
    set_agu(0, 5'd2, 16'h0040);
    tick();
    bus.commit_cnt = 2'd1;
    tick();
    check("wake_senior", 64'(bus.num_senior), 64'd1);
    check("wake_en",     64'(bus.dc_wr_en),   64'd1);
    check("wake_data",   bus.dc_wr_data,      64'hAB);
    check("wake_addr",   64'(bus.dc_wr_addr), 64'h40);
    bus.dc_wr_ready = 1'b1;
    tick();
    bus.dc_wr_ready = 1'b0;
    chk_ptrs("wake_drain", 4'd1, 4'd1, 5'd16, 5'd0);
    check("wake_drain_en", 64'(bus.dc_wr_en), 64'd0);

    // Drain holds while ready is low, lane 1 alone dispatches into tail.
    set_disp(1, 2'd2, 64'h11223344, 1'b1, 6'd0, 5'd3);
    tick();
    set_agu(1, 5'd3, 16'h0100);
    tick();
    bus.commit_cnt = 2'd1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("hold%0d_en", c),   64'(bus.dc_wr_en),   64'd1);
      check($sformatf("hold%0d_addr", c), 64'(bus.dc_wr_addr), 64'h100);
      tick();
    end
    bus.dc_wr_ready = 1'b1;
    #1;
    check("hold4_en",   64'(bus.dc_wr_en),   64'd1);
    check("hold4_data", bus.dc_wr_data,      64'h11223344);
    check("hold4_size", 64'(bus.dc_wr_size), 64'd2);
    tick();
    bus.dc_wr_ready = 1'b0;
    check("pop_en", 64'(bus.dc_wr_en), 64'd0);
    chk_ptrs("pop", 4'd2, 4'd2, 5'd16, 5'd0);

    // Forwarding and disambiguation.
    set_disp(0, 2'd3, 64'h8877665544332211, 1'b1, 6'd0, 5'd4);
    tick();
    set_agu(0, 5'd4, 16'h0100);
    tick();
    set_ld(16'h0102, 2'd1, 4'd3); chk_ld("fwd_half",  1'b1, 1'b0, 64'h4433);
    set_ld(16'h0106, 2'd2, 4'd3); chk_ld("partial",   1'b0, 1'b1, 64'd0);
    set_ld(16'h0102, 2'd1, 4'd2); chk_ld("not_older", 1'b0, 1'b0, 64'd0);
    set_ld(16'h0200, 2'd0, 4'd3); chk_ld("no_ovl",    1'b0, 1'b0, 64'd0);
    set_ld(16'h0102, 2'd1, 4'd3);
    bus.ld_valid = 1'b0;
    #1;
    chk_ld("ld_idle", 1'b0, 1'b0, 64'd0);
    set_disp(0, 2'd2, 64'hDEADBEEF, 1'b1, 6'd0, 5'd5);
    tick();
    set_ld(16'h0200, 2'd0, 4'd4); chk_ld("unres", 1'b0, 1'b1, 64'd0);
    set_agu(0, 5'd5, 16'h0104);
    tick();
    set_ld(16'h0104, 2'd2, 4'd4); chk_ld("young_word", 1'b1, 1'b0, 64'hDEADBEEF);
    set_ld(16'h0105, 2'd0, 4'd4); chk_ld("young_byte", 1'b1, 1'b0, 64'hBE);
    set_ld(16'h0100, 2'd3, 4'd4); chk_ld("young_part", 1'b0, 1'b1, 64'd0);
    set_ld(16'h0101, 2'd0, 4'd4); chk_ld("old_byte",   1'b1, 1'b0, 64'h22);
    bus.except = 1'b1;
    tick();
    chk_ptrs("flush1", 4'd2, 4'd2, 5'd16, 5'd0);

    // Exception with same-cycle commit keeps seniors; dispatch ignored.
    set_disp(0, 2'd3, 64'h6666, 1'b1, 6'd0, 5'd6);
    set_disp(1, 2'd3, 64'h7777, 1'b1, 6'd0, 5'd7);
    tick();
    set_disp(0, 2'd3, 64'h8888, 1'b1, 6'd0, 5'd8);
    set_disp(1, 2'd3, 64'h9999, 1'b1, 6'd0, 5'd9);
    tick();
    set_agu(0, 5'd6, 16'h0300);
    set_agu(1, 5'd7, 16'h0308);
    tick();
    bus.commit_cnt = 2'd2;
    bus.except     = 1'b1;
    set_disp(0, 2'd3, 64'hAAAA, 1'b1, 6'd0, 5'd10);
    tick();
    chk_ptrs("exc", 4'd2, 4'd4, 5'd14, 5'd2);
    check("exc_en",   64'(bus.dc_wr_en),   64'd1);
    check("exc_addr", 64'(bus.dc_wr_addr), 64'h300);
    check("exc_data", bus.dc_wr_data,      64'h6666);
    bus.dc_wr_ready = 1'b1;
    tick();
    chk_ptrs("exc_dr1", 4'd3, 4'd4, 5'd15, 5'd1);
    check("exc_dr1_addr", 64'(bus.dc_wr_addr), 64'h308);
    check("exc_dr1_data", bus.dc_wr_data,      64'h7777);
    tick();
    chk_ptrs("exc_dr2", 4'd4, 4'd4, 5'd16, 5'd0);
    check("exc_dr2_en", 64'(bus.dc_wr_en), 64'd0);

    // Move head to 12 by streaming eight stores through commit and drain.
    for (int i = 0; i < 4; i++) begin
      set_disp(0, 2'd0, 64'(i), 1'b1, 6'd0, 5'(2 * i));
      set_disp(1, 2'd0, 64'(i), 1'b1, 6'd0, 5'(2 * i + 1));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_agu(0, 5'(2 * i),     16'(16'h0400 + 16 * i));
      set_agu(1, 5'(2 * i + 1), 16'(16'h0408 + 16 * i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      bus.commit_cnt = 2'd2;
      tick();
    end
    for (int c = 0; c < 20 && bus.num_free != 5'd16; c++) begin
      tick();
    end
    bus.dc_wr_ready = 1'b0;
    chk_ptrs("wrap_empty", 4'd12, 4'd12, 5'd16, 5'd0);

    // Fill all entries across the wrap, then drain and dispatch in one cycle.
    for (int i = 0; i < 8; i++) begin
      set_disp(0, 2'd0, 64'(i), 1'b1, 6'd0, 5'(2 * i));
      set_disp(1, 2'd0, 64'(i), 1'b1, 6'd0, 5'(2 * i + 1));
      tick();
    end
    chk_ptrs("full", 4'd12, 4'd12, 5'd0, 5'd0);
    set_agu(0, 5'd0, 16'h0500);
    tick();
    bus.commit_cnt = 2'd1;
    tick();
    check("full_senior", 64'(bus.num_senior), 64'd1);
    check("full_en",     64'(bus.dc_wr_en),   64'd1);
    check("full_addr",   64'(bus.dc_wr_addr), 64'h500);
    bus.dc_wr_ready = 1'b1;
    set_disp(0, 2'd0, 64'h5A, 1'b1, 6'd0, 5'd16);
    tick();
    bus.dc_wr_ready = 1'b0;
    chk_ptrs("full_swap", 4'd13, 4'd13, 5'd0, 5'd0);
    check("full_swap_en", 64'(bus.dc_wr_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
- Parametrised next-generation store queue between dispatch, AGU/CDB writeback, ROB commit and the D$ write port.
- Adds senior-store retention: committed stores drain to D$ through a ready/valid handshake and survive exceptions.
- Adds multi-store commit per cycle and a combinational store-to-load forwarding and disambiguation port for the load buffer.

Parameters:
DEPTH, 16, entries; power of 2, >=4
WAYS, 2, dispatch, CDB and AGU lanes
ROB_SZ, 32, ROB entries; ROB_W=$clog2(ROB_SZ)
PRF_SZ, 64, physical registers; PRF_W=$clog2(PRF_SZ)
ADDR_W, 16, byte address width
DATA_W, 64, store data width; sizes BYTE/HALF/WORD/DOUBLE = 1/2/4/8 bytes

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
except  in  1  flush all uncommitted entries
commit_cnt  in  $clog2(WAYS)+1  stores the ROB retires this cycle
disp_en  in  WAYS  per-lane dispatch valid; lanes need not be contiguous
disp_size  in  WAYS x 2  access size
disp_data  in  WAYS x DATA_W  store data
disp_data_valid  in  WAYS  data ready; otherwise waits on disp_tag
disp_tag  in  WAYS x PRF_W  PRF tag of store data
disp_rob_idx  in  WAYS x ROB_W  ROB index
cdb_valid/cdb_tag/cdb_data  in  WAYS x (1/PRF_W/DATA_W)  result broadcast
agu_valid/agu_rob_idx/agu_addr  in  WAYS x (1/ROB_W/ADDR_W)  resolved address
ld_valid  in  1  forwarding lookup request
ld_addr  in  ADDR_W  load address
ld_size  in  2  load size
ld_sq_tail  in  $clog2(DEPTH)  sq_tail snapshot taken at load dispatch; marks the age boundary
ld_fwd_hit  out  1  forwarded data valid
ld_fwd_data  out  DATA_W  forwarded data, zero-extended, LSB-aligned
ld_stall  out  1  load must wait
dc_wr_en  out  1  D$ write valid
dc_wr_ready  in  1  D$ accepts write
dc_wr_addr/dc_wr_data/dc_wr_size  out  ADDR_W/DATA_W/2  head store
sq_head, sq_tail  out  $clog2(DEPTH)  pointers
num_free  out  $clog2(DEPTH)+1  free entries, registered
num_senior  out  $clog2(DEPTH)+1  committed, not yet written entries

Behaviour:
- Entry fields: size, data, data_valid, tag, rob_idx, addr, addr_valid, committed, valid.
- Reset: all valid=0, committed=0; head=tail=0; num_free=DEPTH; num_senior=0. dc_wr_en, ld_fwd_hit and ld_stall are 0 in the reset cycle.
- Dispatch:
  - Enabled lanes are compacted in lane order into tail, tail+1, ... mod DEPTH; tail advances by popcount(disp_en).
  - Caller guarantees popcount(disp_en) <= num_free; exceeding it is an assertion failure.
  - New entry has committed=0, addr_valid=0.
  - Same-cycle CDB match on disp_tag captures cdb_data and sets data_valid=1, so no wakeup is lost.
- CDB: every valid entry with data_valid=0 whose tag equals a valid cdb_tag captures the lowest-lane match and sets data_valid=1 next edge.
- AGU: each valid agu lane writes addr and sets addr_valid on the valid entry whose rob_idx matches. No match means no effect.
- Commit: the oldest commit_cnt entries with committed=0 get committed=1 and num_senior increases by commit_cnt. Caller guarantees these entries are valid with addr_valid=1 and data_valid=1.
- Drain:
  - dc_wr_en = head valid && head committed; fields come from entries[head].
  - On dc_wr_en && dc_wr_ready: head valid=0, head++ mod DEPTH, num_senior--, num_free++.
  - At most one drain per cycle; outputs hold stable while ready=0.
- num_free(next) = num_free - dispatched + drained.
- Except:
  - Applied after same-cycle commit and drain, so commits that cycle are preserved.
  - Invalidates every committed=0 entry; dispatch that cycle is ignored.
  - tail <= new_head + new_num_senior; num_free <= DEPTH - new_num_senior.
- Forwarding (combinational; qualified by ld_valid, else all 0):
  - Searched stores are the valid entries from head up to, but excluding, ld_sq_tail. This includes senior stores.
  - Any searched store with addr_valid=0 sets ld_stall=1.
  - Otherwise take the youngest searched store whose byte range [addr, addr+bytes) overlaps the load range.
  - If it fully covers the load and data_valid=1: ld_fwd_hit=1 and ld_fwd_data = (data >> 8*(ld_addr-addr)) masked to load bytes.
  - If it covers only partially, or data_valid=0: ld_stall=1.
  - If no store overlaps: both outputs 0.
  - Address range arithmetic uses ADDR_W+1 bits, with no wrap at the top of memory.
- Wrap-around: all indices are mod DEPTH; full is num_free=0, empty is num_free=DEPTH. Head==tail is disambiguated only by num_free.

Test Plan:
- Reset, then dispatch 2 stores (lanes 0,1) -> sq_tail=2, num_free=14, dc_wr_en=0.
- Dispatch store with data_valid=0, tag=5; CDB tag=5 data=0xAB on the same cycle -> entry data_valid=1, data=0xAB.
- Store WORD @0x100 data 0x11223344 committed; dc_wr_ready low 3 cycles, then high -> dc_wr_en held 4 cycles, pop on cycle 4, num_free back to 16.
- Older store DOUBLE @0x100 data 0x8877665544332211; load HALF @0x102 -> ld_fwd_hit=1, ld_fwd_data=0x4433. Load WORD @0x106 -> ld_stall=1 (partial overlap).
- 4 stores, 2 committed, dc_wr_ready=0, except=1 -> num_senior=2, tail=head+2, num_free=14; the 2 seniors then drain.
- Fill to DEPTH across wrap (head=12) -> num_free=0; one drain plus one dispatch same cycle -> num_free stays 0.
